// File: rtl/sha256_host_pkg.sv
// Shared types and sizes for the SHA-256 host controller.
// Holds the FSM state enum and the SRAM request bundle.
package sha256_host_pkg;

  localparam int HASH_WORDS = 8;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RD_ADDR,
    RD_DATA,
    PRESENT
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sha256_mem_mux.sv
// SRAM request mux between the host controller and the SHA-256 core.
// The core is selected only while it holds the grant.
module sha256_mem_mux
  import sha256_host_pkg::*;
(
  input  logic     grant_i,
  input  mem_req_t host_i,
  input  mem_req_t core_i,
  output mem_req_t mem_o
);

  assign mem_o = grant_i ? core_i : host_i;

endmodule

// File: rtl/sha256_host_ctrl.sv
// Host controller: loads the message into SRAM, runs the core, streams the hash.
// Optional run-length counter on hash_cycles when HOST_CYCLE_COUNT_EN is defined.
module sha256_host_ctrl
  import sha256_host_pkg::*;
#(
  parameter int                NUM_OF_WORDS = 20,
  parameter logic [ADDR_W-1:0] MSG_ADDR     = 16'd0,
  parameter logic [ADDR_W-1:0] OUT_ADDR     = 16'd1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [31:0]       hash_cycles,
  output logic              sha_start,
  output logic [ADDR_W-1:0] sha_message_addr,
  output logic [ADDR_W-1:0] sha_output_addr,
  input  logic              sha_done,
  input  logic              sha_mem_we,
  input  logic [ADDR_W-1:0] sha_mem_addr,
  input  logic [DATA_W-1:0] sha_mem_write_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [ADDR_W-1:0] LAST_I = ADDR_W'(NUM_OF_WORDS - 1);
  localparam logic [2:0]        LAST_J = 3'(HASH_WORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [2:0]        j_q, j_d;
  logic              st_q, st_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              accept;
  logic              grant;
  logic              rd_phase;
  mem_req_t          host_req, core_req, mem_req;

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign accept    = in_valid && in_ready;
  assign grant     = (state_q == WAIT);
  assign busy      = (state_q != IDLE);
  assign sha_start = (state_q == START);
  assign out_valid = (state_q == PRESENT);
  assign out_last  = out_valid && (j_q == LAST_J);
  assign out_data  = out_q;

  assign sha_message_addr = MSG_ADDR;
  assign sha_output_addr  = OUT_ADDR;

  assign rd_phase = state_q inside {RD_ADDR, RD_DATA, PRESENT};

  assign host_req.we    = accept;
  assign host_req.addr  = rd_phase ? OUT_ADDR + {13'b0, j_q}
                                   : MSG_ADDR + i_q;
  assign host_req.wdata = in_data;

  assign core_req.we    = sha_mem_we;
  assign core_req.addr  = sha_mem_addr;
  assign core_req.wdata = sha_mem_write_data;

  sha256_mem_mux u_mux (
    .grant_i (grant),
    .host_i  (host_req),
    .core_i  (core_req),
    .mem_o   (mem_req)
  );

  assign mem_we         = mem_req.we;
  assign mem_addr       = mem_req.addr;
  assign mem_write_data = mem_req.wdata;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    st_d    = 1'b0;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          i_d     = ADDR_W'(1);
          state_d = (NUM_OF_WORDS == 1) ? START : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          i_d = i_q + 1'b1;
          if (i_q == LAST_I) state_d = START;
        end
      end
      // st_q marks the second of the two start cycles
      START: begin
        st_d = ~st_q;
        if (st_q) state_d = WAIT;
      end
      WAIT: begin
        if (sha_done) begin
          j_d     = '0;
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        out_d   = mem_read_data;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          if (j_q == LAST_J) begin
            i_d     = '0;
            state_d = IDLE;
          end else begin
            j_d     = j_q + 1'b1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      st_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      st_q    <= st_d;
      out_q   <= out_d;
    end
  end

`ifdef HOST_CYCLE_COUNT_EN
  logic [31:0] hc_q, hc_d;

  // freezes on the done cycle, holds until the next run starts
  always_comb begin
    hc_d = hc_q;
    if (state_d == START && state_q != START) begin
      hc_d = '0;
    end else if (state_q == START ||
                 (state_q == WAIT && !sha_done)) begin
      hc_d = hc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hc_q <= '0;
    else       hc_q <= hc_d;
  end

  assign hash_cycles = hc_q;
`else
  assign hash_cycles = '0;
`endif

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Randomized bench: SRAM model, behavioural SHA-256 core stub and reference.
// Checks load, core handoff, hash readback, stalls, reset abort and stray done.
module tb_sha256_host_ctrl;

  localparam int          NW   = 20;
  localparam logic [15:0] MSG  = 16'd0;
  localparam logic [15:0] OUTA = 16'd1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy;
  logic [31:0] hash_cycles;
  logic        sha_start, sha_done;
  logic [15:0] sha_message_addr, sha_output_addr;
  logic        sha_mem_we;
  logic [15:0] sha_mem_addr;
  logic [31:0] sha_mem_write_data;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  sha256_host_ctrl #(
    .NUM_OF_WORDS (NW),
    .MSG_ADDR     (MSG),
    .OUT_ADDR     (OUTA)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .busy               (busy),
    .hash_cycles        (hash_cycles),
    .sha_start          (sha_start),
    .sha_message_addr   (sha_message_addr),
    .sha_output_addr    (sha_output_addr),
    .sha_done           (sha_done),
    .sha_mem_we         (sha_mem_we),
    .sha_mem_addr       (sha_mem_addr),
    .sha_mem_write_data (sha_mem_write_data),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_read_data      (mem_read_data)
  );

  logic [31:0] sram [0:2047];

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr[10:0]] <= mem_write_data;
    mem_read_data <= sram[mem_addr[10:0]];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Plain SHA-256 over a word queue; result packed H0 in the top bits
  function automatic logic [255:0] sha256_ref(input logic [31:0] msg[$]);
    logic [31:0] p[$];
    logic [31:0] w[64];
    logic [31:0] h[8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [255:0] r;
    p = msg;
    p.push_back(32'h80000000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(msg.size() * 32));
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < p.size() / 16; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = p[blk * 16 + t];
      for (int t = 16; t < 64; t++)
        w[t] = w[t-16] + w[t-7]
             + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3))
             + (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10));
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25))
           + ((e & f) ^ (~e & g)) + K[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1;
        d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
      h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = h[j];
    return r;
  endfunction

  task automatic load(input logic [31:0] ws[$], input bit gap,
                      input int done_at);
    logic [15:0] wa[$];
    logic [31:0] wd[$];
    int i, c;
    i = 0;
    c = 0;
    while (i < NW && c < 500) begin
      @(negedge clk);
      in_valid = gap ? (c % 2 == 0) : 1'b1;
      in_data  = in_valid ? ws[i] : $urandom;
      sha_done = (c == done_at);
      #1;
      if (mem_we) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_write_data);
      end
      if (in_valid && in_ready) i++;
      c++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    sha_done = 1'b0;
    #1;
    check("words_accepted", i, NW);
    check("host_writes", wa.size(), NW);
    for (int k = 0; k < NW && k < wa.size(); k++) begin
      check($sformatf("wr_addr%0d", k), {16'h0, wa[k]}, {16'h0, MSG} + k);
      check($sformatf("wr_data%0d", k), wd[k], ws[k]);
      check($sformatf("sram%0d", k), sram[MSG[10:0] + 11'(k)], ws[k]);
    end
  endtask

  // Core stub: reads the message through the granted bus, hashes, writes back
  task automatic run_core(input int abort_at);
    logic [31:0] rd[$];
    logic [255:0] hv;
    int n, st_cyc, wait_cyc;
    logic [31:0] hc_exp;
    n = 0;
    while (!sha_start && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("start_seen", sha_start, 1'b1);
    st_cyc = 0;
    while (sha_start && st_cyc < 10) begin
      st_cyc++;
      @(negedge clk); #1;
    end
    check("start_len", st_cyc, 2);
    check("in_ready_wait", in_ready, 1'b0);
    wait_cyc = 0;
    for (int k = 0; k <= NW; k++) begin
      if (k > 0) rd.push_back(mem_read_data);
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_start", sha_start, 1'b0);
        check("rst_oval", out_valid, 1'b0);
        @(negedge clk); #1;
        check("rst_busy_next", busy, 1'b0);
        check("rst_start_next", sha_start, 1'b0);
        check("rst_oval_next", out_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk); #1;
        return;
      end
      sha_mem_we   = 1'b0;
      sha_mem_addr = MSG + 16'(k);
      wait_cyc++;
      @(negedge clk); #1;
    end
    hv = sha256_ref(rd);
    for (int j = 0; j < 8; j++) begin
      sha_mem_we         = 1'b1;
      sha_mem_addr       = OUTA + 16'(j);
      sha_mem_write_data = hv[255 - 32*j -: 32];
      wait_cyc++;
      @(negedge clk); #1;
    end
    sha_mem_we = 1'b0;
    sha_done   = 1'b1;
    @(negedge clk);
    sha_done = 1'b0;
    #1;
`ifdef HOST_CYCLE_COUNT_EN
    hc_exp = 32'(2 + wait_cyc);
`else
    hc_exp = 32'd0;
`endif
    check("hash_cycles", hash_cycles, hc_exp);
  endtask

  task automatic drain(input int mode, input logic [255:0] hv);
    logic [3:0]  pat;
    logic [31:0] held;
    bit stalled;
    int j, c;
    pat = 4'b1001;
    j = 0;
    c = 0;
    stalled = 0;
    held = '0;
    while (j < 8 && c < 300) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[3 - (c % 4)];
        default: out_ready = 1'($urandom % 2);
      endcase
      #1;
      if (out_valid) begin
        if (stalled) check("stall_hold", out_data, held);
        if (out_ready) begin
          check($sformatf("hash%0d", j), out_data, hv[255 - 32*j -: 32]);
          check($sformatf("last%0d", j), out_last, (j == 7));
          j++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = out_data;
        end
      end
      c++;
    end
    check("hash_words_out", j, 8);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("idle_busy", busy, 1'b0);
    check("idle_oval", out_valid, 1'b0);
  endtask

  task automatic full_run(input logic [31:0] ws[$], input bit gap,
                          input int done_at, input int mode);
    load(ws, gap, done_at);
    run_core(-1);
    drain(mode, sha256_ref(ws));
  endtask

  logic [31:0] words[$];
  logic [31:0] rw[$];
  logic [31:0] w;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    sha_done = 1'b0;
    sha_mem_we = 1'b0;
    sha_mem_addr = '0;
    sha_mem_write_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy0", busy, 1'b0);
    check("rst_sha_start0", sha_start, 1'b0);
    check("rst_out_valid0", out_valid, 1'b0);
    check("rst_out_last0", out_last, 1'b0);
    check("rst_out_data0", out_data, 32'h0);
    check("rst_mem_we0", mem_we, 1'b0);
    check("rst_hash_cycles0", hash_cycles, 32'h0);
    check("msg_addr", sha_message_addr, MSG);
    check("out_addr", sha_output_addr, OUTA);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    sha_done = 1'b1;
    @(negedge clk);
    sha_done = 1'b0;
    #1;
    check("done_in_idle", busy, 1'b0);
    check("done_in_idle_start", sha_start, 1'b0);

    w = 32'h01234675;
    for (int k = 0; k < NW; k++) begin
      words.push_back(w);
      w = {w[30:0], w[31]};
    end
    full_run(words, 1'b0, 3, 0);
    full_run(words, 1'b0, -1, 1);

    for (int k = 0; k < NW; k++) rw.push_back($urandom);
    full_run(rw, 1'b1, 5, 0);

    rw.delete();
    for (int k = 0; k < NW; k++) rw.push_back($urandom);
    load(rw, 1'b0, -1);
    run_core(5);
    check("sram_kept", sram[MSG[10:0]], rw[0]);
    check("idle_after_abort", busy, 1'b0);

    rw.delete();
    for (int k = 0; k < NW; k++) rw.push_back($urandom);
    full_run(rw, 1'b0, -1, 2);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
